// File: rtl/multi_cycle_control_pkg.sv
// ---------------------------------------------------------------------------
// control_defs
// Shared definitions for the multi-cycle control unit, the datapath and the
// bench: instruction opcodes, FSM state encodings, the select codes for
// ALUOp / RegDst / PCSrc, the bundled control-word struct, and small opcode
// classification helpers.
// ---------------------------------------------------------------------------
package control_defs;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLTI  = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // FSM states; the encoding is visible on the debug port
  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  // Write-register select codes
  localparam logic [1:0] REG_DST_RA = 2'b00;
  localparam logic [1:0] REG_DST_RT = 2'b01;
  localparam logic [1:0] REG_DST_RD = 2'b10;

  // Next-PC select codes
  localparam logic [1:0] PC_SRC_NEXT   = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_RS     = 2'b10;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b11;

  // Full control word produced by the decoder
  typedef struct packed {
    logic       pcWre;
    logic       irWre;
    logic       regWre;
    logic [1:0] regDst;
    logic       wrRegDSrc;
    logic       dbDataSrc;
    logic       aluSrcB;
    logic       extSel;
    logic [2:0] aluOp;
    logic [1:0] pcSrc;
    logic       mRD;
    logic       mWR;
  } ctrl_t;

  function automatic logic isAluGroup(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDIU) ||
           (op == OP_AND) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

  // Register-register ALU ops write rd; the immediate forms write rt
  function automatic logic isRType(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  function automatic logic isLoadStore(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic isBranch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic isKnown(input logic [5:0] op);
    return isAluGroup(op) || isLoadStore(op) || isBranch(op) ||
           (op == OP_J) || (op == OP_JR) || (op == OP_JAL) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/multi_cycle_control_decode.sv
// ---------------------------------------------------------------------------
// control_decode
// Purely combinational map from (state, opcode, zero) to the full datapath
// control word. Enables are only raised in the state that owns them; the
// operand/ALU selects follow the opcode alone.
//   state   in  3  current FSM state
//   opcode  in  6  registered instruction opcode
//   zero    in  1  ALU zero flag (only meaningful in EXE_BR)
//   ctrl    out    control word (see control_defs::ctrl_t)
// ---------------------------------------------------------------------------
module control_decode
  import control_defs::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  output ctrl_t      ctrl
);

  logic branchTaken;

  assign branchTaken = ((opcode == OP_BEQ) &&  zero) ||
                       ((opcode == OP_BNE) && !zero);

  always_comb begin
    ctrl           = '0;
    ctrl.wrRegDSrc = 1'b1;
    ctrl.extSel    = (opcode != OP_ORI);
    ctrl.aluSrcB   = (opcode == OP_ADDIU) || (opcode == OP_ORI) ||
                     (opcode == OP_SLTI)  || isLoadStore(opcode);
    case (opcode)
      OP_SUB, OP_BEQ, OP_BNE: ctrl.aluOp = ALU_SUB;
      OP_AND:                 ctrl.aluOp = ALU_AND;
      OP_ORI:                 ctrl.aluOp = ALU_OR;
      OP_SLTI:                ctrl.aluOp = ALU_SLT;
      default:                ctrl.aluOp = ALU_ADD;
    endcase

    case (state)
      S_IF: ctrl.irWre = 1'b1;

      // Jumps and unknown opcodes retire in ID; HALT deliberately leaves
      // the PC alone so the same word is fetched again.
      S_ID: begin
        if ((opcode == OP_J) || (opcode == OP_JAL)) ctrl.pcSrc = PC_SRC_JUMP;
        else if (opcode == OP_JR)                   ctrl.pcSrc = PC_SRC_RS;
        if ((opcode == OP_J) || (opcode == OP_JR) || (opcode == OP_JAL) ||
            !isKnown(opcode))
          ctrl.pcWre = 1'b1;
        if (opcode == OP_JAL) begin
          ctrl.regWre    = 1'b1;
          ctrl.regDst    = REG_DST_RA;
          ctrl.wrRegDSrc = 1'b0;
        end
      end

      S_EXE_BR: begin
        ctrl.pcWre = 1'b1;
        ctrl.pcSrc = branchTaken ? PC_SRC_BRANCH : PC_SRC_NEXT;
      end

      S_MEM: begin
        if (opcode == OP_LW) ctrl.mRD = 1'b1;
        if (opcode == OP_SW) begin
          ctrl.mWR   = 1'b1;
          ctrl.pcWre = 1'b1;
        end
      end

      S_WB_AL: begin
        ctrl.regWre = 1'b1;
        ctrl.pcWre  = 1'b1;
        ctrl.regDst = isRType(opcode) ? REG_DST_RD : REG_DST_RT;
      end

      S_WB_LD: begin
        ctrl.regWre    = 1'b1;
        ctrl.pcWre     = 1'b1;
        ctrl.regDst    = REG_DST_RT;
        ctrl.dbDataSrc = 1'b1;
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// ---------------------------------------------------------------------------
// multi_cycle_control
// Multi-cycle CPU control unit: holds the IF/ID/EXE/MEM/WB state register
// and next-state logic, and exposes the decoded datapath controls.
//   CLK        in   system clock (rising edge)
//   Reset      in   asynchronous active-high reset, state -> IF
//   opcode     in   instruction[31:26] from the instruction register
//   zero       in   ALU zero flag, used in EXE_BR
//   state      out  current state (debug)
//   PCWre, IRWre, RegWre, mRD, mWR           out  enables
//   RegDst, WrRegDSrc, DBDataSrc, ALUSrcB,
//   ExtSel, ALUOp, PCSrc                     out  selects
// ---------------------------------------------------------------------------
module multi_cycle_control
  import control_defs::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic [2:0] state,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       mRD,
  output logic       mWR
);

  state_t curState;
  state_t nextState;
  ctrl_t  ctrlDec;
  ctrl_t  ctrlOut;

  always_comb begin
    nextState = S_IF;
    case (curState)
      S_IF: nextState = S_ID;
      S_ID: begin
        if (isAluGroup(opcode))       nextState = S_EXE_AL;
        else if (isLoadStore(opcode)) nextState = S_EXE_LS;
        else if (isBranch(opcode))    nextState = S_EXE_BR;
        else                          nextState = S_IF;
      end
      S_EXE_AL: nextState = S_WB_AL;
      S_EXE_LS: nextState = S_MEM;
      S_MEM:    nextState = (opcode == OP_LW) ? S_WB_LD : S_IF;
      default:  nextState = S_IF;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) curState <= S_IF;
    else       curState <= nextState;
  end

  control_decode uDecode (
    .state  (curState),
    .opcode (opcode),
    .zero   (zero),
    .ctrl   (ctrlDec)
  );

  // While Reset is held the state already reads IF, but IF would raise
  // IRWre; everything is forced quiet until Reset drops.
  always_comb begin
    ctrlOut = Reset ? '0 : ctrlDec;
  end

  assign state     = curState;
  assign PCWre     = ctrlOut.pcWre;
  assign IRWre     = ctrlOut.irWre;
  assign RegWre    = ctrlOut.regWre;
  assign RegDst    = ctrlOut.regDst;
  assign WrRegDSrc = ctrlOut.wrRegDSrc;
  assign DBDataSrc = ctrlOut.dbDataSrc;
  assign ALUSrcB   = ctrlOut.aluSrcB;
  assign ExtSel    = ctrlOut.extSel;
  assign ALUOp     = ctrlOut.aluOp;
  assign PCSrc     = ctrlOut.pcSrc;
  assign mRD       = ctrlOut.mRD;
  assign mWR       = ctrlOut.mWR;

endmodule

// File: tb/tb_multi_cycle_control.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_control
// Runs directed and random instructions through the control unit, with the
// expected behaviour of each cycle derived from the instruction class and
// the cycle's position within the instruction. Random mid-instruction
// resets check that aborted instructions leave no write behind.
// ---------------------------------------------------------------------------
module tb_multi_cycle_control;
  import control_defs::*;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] opcode;
  logic       zero;
  logic [2:0] state;
  logic       PCWre, IRWre, RegWre, WrRegDSrc, DBDataSrc, ALUSrcB, ExtSel;
  logic       mRD, mWR;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp;

  int checks = 0;
  int errors = 0;

  localparam int CLS_ALU = 0;
  localparam int CLS_SW  = 1;
  localparam int CLS_LW  = 2;
  localparam int CLS_BR  = 3;
  localparam int CLS_TWO = 4;

  multi_cycle_control dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .opcode    (opcode),
    .zero      (zero),
    .state     (state),
    .PCWre     (PCWre),
    .IRWre     (IRWre),
    .RegWre    (RegWre),
    .RegDst    (RegDst),
    .WrRegDSrc (WrRegDSrc),
    .DBDataSrc (DBDataSrc),
    .ALUSrcB   (ALUSrcB),
    .ExtSel    (ExtSel),
    .ALUOp     (ALUOp),
    .PCSrc     (PCSrc),
    .mRD       (mRD),
    .mWR       (mWR)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int classOf(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010,
      6'b010000, 6'b010010, 6'b100111: return CLS_ALU;
      6'b110000:                       return CLS_SW;
      6'b110001:                       return CLS_LW;
      6'b110100, 6'b110101:            return CLS_BR;
      default:                         return CLS_TWO;
    endcase
  endfunction

  function automatic int cyclesOf(input int cls);
    case (cls)
      CLS_ALU, CLS_SW: return 4;
      CLS_LW:          return 5;
      CLS_BR:          return 3;
      default:         return 2;
    endcase
  endfunction

  // State visited at step k of an instruction of class cls
  function automatic int expState(input int cls, input int k);
    if (k == 0) return 0;
    if (k == 1) return 1;
    case (cls)
      CLS_ALU:        return (k == 2) ? 6 : 7;
      CLS_SW, CLS_LW: return (k == 2) ? 2 : (k == 3) ? 3 : 4;
      default:        return 5;
    endcase
  endfunction

  function automatic int expAluOp(input logic [5:0] op);
    case (op)
      OP_SUB, OP_BEQ, OP_BNE: return 1;
      OP_AND:                 return 4;
      OP_ORI:                 return 3;
      OP_SLTI:                return 6;
      default:                return 0;
    endcase
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".state"}, state, 0);
    checkOutput({tag, ".outs"},
                {PCWre, IRWre, RegWre, RegDst, WrRegDSrc, DBDataSrc, ALUSrcB,
                 ExtSel, ALUOp, PCSrc, mRD, mWR}, 0);
  endtask

  // Runs one instruction starting in IF (called 1 time unit after a rising
  // edge or after reset release). If abortAt < instruction length, Reset is
  // raised at that step instead of completing the instruction.
  task automatic applyStimulus(input logic [5:0] op, input logic z, input int abortAt);
    int  cls, n;
    bit  eRegWre, ePcWre, taken;
    int  ePcSrc;
    cls   = classOf(op);
    n     = cyclesOf(cls);
    taken = ((op == OP_BEQ) && z) || ((op == OP_BNE) && !z);
    for (int k = 0; k < n; k++) begin
      if (k == abortAt) begin
        Reset = 1'b1;
        #1;
        checkResetOutputs("abort");
        @(posedge CLK);
        #1;
        checkResetOutputs("abortHold");
        Reset = 1'b0;
        return;
      end
      opcode = (k == 0) ? 6'($urandom) : op;
      zero   = (k == 2) ? z : 1'($urandom);
      #1;
      eRegWre = ((cls == CLS_ALU || cls == CLS_LW) && k == n - 1) ||
                (op == OP_JAL && k == 1);
      ePcWre  = (k == n - 1) && (op != OP_HALT);
      checkOutput("state",  state,  expState(cls, k));
      checkOutput("IRWre",  IRWre,  k == 0);
      checkOutput("PCWre",  PCWre,  ePcWre);
      checkOutput("RegWre", RegWre, eRegWre);
      checkOutput("mRD",    mRD,    (cls == CLS_LW) && (k == 3));
      checkOutput("mWR",    mWR,    (cls == CLS_SW) && (k == 3));
      if (eRegWre) begin
        if (op == OP_JAL)       checkOutput("RegDst", RegDst, 0);
        else if (cls == CLS_LW) checkOutput("RegDst", RegDst, 1);
        else checkOutput("RegDst", RegDst,
                         (op == OP_ADD || op == OP_SUB || op == OP_AND) ? 2 : 1);
        checkOutput("WrRegDSrc", WrRegDSrc, op != OP_JAL);
        if (cls == CLS_LW) checkOutput("DBDataSrc", DBDataSrc, 1);
      end
      if (ePcWre) begin
        if (op == OP_J || op == OP_JAL) ePcSrc = 3;
        else if (op == OP_JR)           ePcSrc = 2;
        else if (cls == CLS_BR)         ePcSrc = taken ? 1 : 0;
        else                            ePcSrc = 0;
        checkOutput("PCSrc", PCSrc, ePcSrc);
      end
      if (k > 0) begin
        checkOutput("ALUOp",   ALUOp,   expAluOp(op));
        checkOutput("ExtSel",  ExtSel,  op != OP_ORI);
        checkOutput("ALUSrcB", ALUSrcB,
                    (op == OP_ADDIU || op == OP_ORI || op == OP_SLTI ||
                     op == OP_LW || op == OP_SW));
      end
      @(posedge CLK);
      #1;
    end
  endtask

  logic [5:0] opTable [14];
  logic [5:0] rOp;
  int         rLen;
  int         rAbort;

  initial begin
    opTable = '{OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ORI, OP_SLTI, OP_SW,
                OP_LW, OP_BEQ, OP_BNE, OP_J, OP_JR, OP_JAL, OP_HALT};
    Reset  = 1'b1;
    opcode = 6'd0;
    zero   = 1'b0;
    #1;
    checkResetOutputs("reset");
    repeat (2) @(posedge CLK);
    #1;
    checkResetOutputs("resetHeld");
    Reset = 1'b0;

    // Directed coverage of the listed scenarios
    applyStimulus(OP_ADD,   1'b0, 99);
    applyStimulus(OP_ADD,   1'b0, 2);
    applyStimulus(OP_LW,    1'b0, 99);
    applyStimulus(OP_BEQ,   1'b1, 99);
    applyStimulus(OP_BEQ,   1'b0, 99);
    applyStimulus(OP_BNE,   1'b0, 99);
    applyStimulus(OP_BNE,   1'b1, 99);
    applyStimulus(OP_JAL,   1'b0, 99);
    applyStimulus(OP_HALT,  1'b0, 99);
    applyStimulus(OP_HALT,  1'b0, 99);
    applyStimulus(OP_HALT,  1'b0, 99);
    applyStimulus(6'b101010, 1'b0, 99);
    applyStimulus(OP_SW,    1'b0, 99);
    applyStimulus(OP_SW,    1'b0, 3);
    applyStimulus(OP_LW,    1'b0, 4);
    applyStimulus(OP_ORI,   1'b0, 99);
    applyStimulus(OP_J,     1'b0, 99);
    applyStimulus(OP_JR,    1'b0, 99);

    // Random instruction stream with occasional aborts
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 13) == 13) rOp = 6'($urandom);
      else                             rOp = opTable[$urandom_range(0, 13)];
      rLen   = cyclesOf(classOf(rOp));
      rAbort = ($urandom_range(0, 7) == 0) ? $urandom_range(1, rLen - 1) : 99;
      applyStimulus(rOp, 1'($urandom), rAbort);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
